input_skew_buffer: RTL and testbench



---
 rtl/tpu_pkg.sv | 21 ++
 rtl/input_skew_buffer_if.sv | 26 ++
 rtl/input_skew_buffer_delay_line.sv | 44 ++++
 rtl/input_skew_buffer.sv | 118 +++++++++++
 tb/tb_input_skew_buffer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared types for the systolic array front end: data word, lane word type and the
// skew buffer FSM encoding.
package tpu_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } skew_state_e;

    // Drain counter width: holds N-1 for any N >= 1.
    function automatic int drain_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/input_skew_buffer_if.sv
// Handshake and wavefront bundle of input_skew_buffer; master is the upstream/array
// side, slave is the skew buffer itself.
interface input_skew_buffer_if #(
    parameter int N = 2
) ();
    import tpu_pkg::*;

    data_t [N-1:0] flat_data_in;
    logic          flat_valid_in;
    logic          last_in;
    logic          in_ready;
    data_t [N-1:0] skewed_data_out;
    logic  [N-1:0] skewed_valid_out;
    logic          busy;
    logic          done;

    modport master (
        output flat_data_in, flat_valid_in, last_in,
        input  in_ready, skewed_data_out, skewed_valid_out, busy, done
    );

    modport slave (
        input  flat_data_in, flat_valid_in, last_in,
        output in_ready, skewed_data_out, skewed_valid_out, busy, done
    );
endinterface

// File: rtl/input_skew_buffer_delay_line.sv
// skew_delay_line: DELAY-stage shift register of {data, valid} for one lane;
// DELAY=0 degenerates to a wire.
module skew_delay_line
    import tpu_pkg::*;
#(
    parameter int DELAY = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  data_t data_i,
    input  logic  valid_i,
    output data_t data_o,
    output logic  valid_o
);

    if (DELAY == 0) begin : g_wire
        assign data_o  = data_i;
        assign valid_o = valid_i;
    end else begin : g_shift
        data_t data_q  [DELAY];
        logic  valid_q [DELAY];

        // Shift every cycle; a non-accepted cycle travels down as a valid=0 bubble.
        always_ff @(posedge clk) begin
            if (!rst) begin
                for (int k = 0; k < DELAY; k++) begin
                    data_q[k]  <= '0;
                    valid_q[k] <= 1'b0;
                end
            end else begin
                data_q[0]  <= data_i;
                valid_q[0] <= valid_i;
                for (int k = 1; k < DELAY; k++) begin
                    data_q[k]  <= data_q[k-1];
                    valid_q[k] <= valid_q[k-1];
                end
            end
        end

        assign data_o  = data_q[DELAY-1];
        assign valid_o = valid_q[DELAY-1];
    end

endmodule

// File: rtl/input_skew_buffer.sv
// Input deskew: lane i delayed by i cycles into a diagonal wavefront, tile closed by
// last_in then drained with done. Optional INPUT_SKEW_ZERO_FILL_EN zeroes invalid lanes.
module input_skew_buffer
    import tpu_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                clk,
    input  logic                rst,
    input_skew_buffer_if.slave  bus
);

    localparam int CNT_W = drain_cnt_w(N);

    skew_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_s;
    logic              busy_s;
    logic              done_s;
    logic              accept_s;
    data_t             lane_data_s  [N];
    logic              lane_valid_s [N];
    data_t [N-1:0]     out_data_s;
    logic  [N-1:0]     out_valid_s;

    assign accept_s = bus.flat_valid_in && in_ready_s;

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_line #(.DELAY(i)) u_delay (
            .clk     (clk),
            .rst     (rst),
            .data_i  (bus.flat_data_in[i]),
            .valid_i (accept_s),
            .data_o  (lane_data_s[i]),
            .valid_o (lane_valid_s[i])
        );
    end

    // Collect lanes into the output vectors, optionally zeroing invalid data.
    always_comb begin
        out_data_s  = '0;
        out_valid_s = '0;
        for (int i = 0; i < N; i++) begin
            out_valid_s[i] = lane_valid_s[i];
`ifdef INPUT_SKEW_ZERO_FILL_EN
            if (lane_valid_s[i]) begin
                out_data_s[i] = lane_data_s[i];
            end else begin
                out_data_s[i] = '0;
            end
`else
            out_data_s[i] = lane_data_s[i];
`endif
        end
    end

    assign bus.skewed_data_out  = out_data_s;
    assign bus.skewed_valid_out = out_valid_s;

    // State and drain counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, drain count and state-decoded handshake flags.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_ready_s = 1'b0;
        busy_s     = (state_q != ST_IDLE);
        done_s     = 1'b0;
        case (state_q)
            ST_IDLE, ST_STREAM: begin
                in_ready_s = 1'b1;
                if (accept_s && bus.last_in) begin
                    if (N == 1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = CNT_W'(N - 1);
                    end
                end else if (accept_s) begin
                    state_d = ST_STREAM;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                done_s  = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready = in_ready_s;
    assign bus.busy     = busy_s;
    assign bus.done     = done_s;

endmodule

// File: tb/tb_input_skew_buffer.sv
// Randomized plus directed bench for input_skew_buffer (N=4 against a cycle-history
// model, N=1 directed); honours INPUT_SKEW_ZERO_FILL_EN like the design.
module tb_input_skew_buffer;
    import tpu_pkg::*;

    localparam int N    = 4;
    localparam int HMAX = 2048;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    input_skew_buffer_if #(.N(N)) bus4 ();
    input_skew_buffer_if #(.N(1)) bus1 ();

    input_skew_buffer #(.N(N)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    input_skew_buffer #(.N(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;

    // Model: what was offered/accepted in every cycle, plus tile bookkeeping.
    data_t [N-1:0] hist_d [HMAX];
    bit            hist_a [HMAX];
    int            cyc       = 0;
    int            rst_cyc   = -1;
    int            last_t    = -1000;
    bit            open_tile = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle on the N=4 instance; called just after a rising edge.
    task automatic cycle(input bit v, input bit l, input data_t [N-1:0] d, input bit r);
        bit    in_win;
        bit    ready_e;
        bit    acc;
        bit    ev;
        data_t ed;
        int    src;
        bus4.flat_valid_in = v;
        bus4.last_in       = l;
        bus4.flat_data_in  = d;
        rst                = r ? 1'b0 : 1'b1;
        in_win  = (cyc > last_t) && (cyc <= last_t + N);
        ready_e = !in_win;
        acc     = v && ready_e;
        hist_a[cyc] = acc;
        hist_d[cyc] = d;
        @(negedge clk);
        check_val("in_ready", 32'(bus4.in_ready), 32'(ready_e));
        check_val("busy", 32'(bus4.busy), 32'(open_tile || in_win));
        check_val("done", 32'(bus4.done), 32'(cyc == last_t + N));
        for (int i = 0; i < N; i++) begin
            src = cyc - i;
            if (i == 0 || src > rst_cyc) begin
                ev = hist_a[src];
                ed = hist_d[src][i];
            end else begin
                ev = 1'b0;
                ed = '0;
            end
`ifdef INPUT_SKEW_ZERO_FILL_EN
            if (!ev) ed = '0;
`endif
            check_val($sformatf("lane%0d_valid", i), 32'(bus4.skewed_valid_out[i]), 32'(ev));
            check_val($sformatf("lane%0d_data", i), 32'(bus4.skewed_data_out[i]), 32'(ed));
        end
        if (r) begin
            last_t    = -1000;
            open_tile = 1'b0;
            rst_cyc   = cyc;
        end else if (acc && l) begin
            last_t    = cyc;
            open_tile = 1'b0;
        end else if (acc) begin
            open_tile = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    // N=1 directed cycle while the N=4 instance sits idle with zero input.
    task automatic n1_cycle(input bit v, input bit l, input data_t d);
        bus1.flat_valid_in = v;
        bus1.last_in       = l;
        bus1.flat_data_in  = d;
        bus4.flat_valid_in = 1'b0;
        bus4.last_in       = 1'b0;
        bus4.flat_data_in  = '0;
        hist_a[cyc] = 1'b0;
        hist_d[cyc] = '0;
        @(negedge clk);
    endtask

    task automatic n1_advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        data_t [N-1:0] d;
        bus4.flat_valid_in = 1'b0;
        bus4.last_in       = 1'b0;
        bus4.flat_data_in  = '0;
        bus1.flat_valid_in = 1'b0;
        bus1.last_in       = 1'b0;
        bus1.flat_data_in  = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state, then N=1: beat -7 with last, then held beat while blocked.
        n1_cycle(1'b1, 1'b1, -16'sd7);
        check_val("n1_data", 32'(bus1.skewed_data_out[0]), 32'(-16'sd7));
        check_val("n1_valid", 32'(bus1.skewed_valid_out[0]), 32'd1);
        check_val("n1_ready0", 32'(bus1.in_ready), 32'd1);
        check_val("n1_done0", 32'(bus1.done), 32'd0);
        n1_advance();
        n1_cycle(1'b1, 1'b1, -16'sd7);
        check_val("n1_ready1", 32'(bus1.in_ready), 32'd0);
        check_val("n1_done1", 32'(bus1.done), 32'd1);
        check_val("n1_valid1", 32'(bus1.skewed_valid_out[0]), 32'd0);
        n1_advance();
        n1_cycle(1'b0, 1'b0, 16'sd0);
        check_val("n1_ready2", 32'(bus1.in_ready), 32'd1);
        check_val("n1_done2", 32'(bus1.done), 32'd0);
        check_val("n1_busy2", 32'(bus1.busy), 32'd0);
        n1_advance();

        // Single beat {4,3,2,1} with last; offers during drain must be refused.
        idle(1);
        cycle(1'b1, 1'b1, {16'sd4, 16'sd3, 16'sd2, 16'sd1}, 1'b0);
        cycle(1'b1, 1'b0, {4{16'sd9}}, 1'b0);
        idle(5);

        // Back-to-back 10, 20, 30 with last on 30.
        cycle(1'b1, 1'b0, {4{16'sd10}}, 1'b0);
        cycle(1'b1, 1'b0, {4{16'sd20}}, 1'b0);
        cycle(1'b1, 1'b1, {4{16'sd30}}, 1'b0);
        idle(6);

        // Bubble mid-tile, with last_in asserted on the bubble (must be ignored).
        cycle(1'b1, 1'b0, {16'sd4, 16'sd3, 16'sd2, 16'sd1}, 1'b0);
        cycle(1'b0, 1'b1, {4{16'sd77}}, 1'b0);
        cycle(1'b1, 1'b1, {16'sd8, 16'sd7, 16'sd6, 16'sd5}, 1'b0);
        idle(6);

        // Unaccepted lane-0 input 0x7FFF.
        cycle(1'b0, 1'b0, {4{16'sh7FFF}}, 1'b0);
        idle(1);

        // Reset one cycle after last: drain aborted, no done.
        cycle(1'b1, 1'b0, {4{-16'sd5}}, 1'b0);
        cycle(1'b1, 1'b1, {4{16'sd6}}, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        idle(6);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) d[i] = data_t'($urandom);
            cycle(1'(($urandom % 4) != 0), 1'(($urandom % 5) == 0), d,
                  1'(($urandom % 80) == 0));
        end
        idle(N + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
